// File: rtl/ebc_rx_pkg.sv
// Shared types for the address-event receiver: word type tags, handshake FSM states and the
// default-configuration event word layout.
package ebc_rx_pkg;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_PIX  = 2'd1,
    EVT_WRAP = 2'd2
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } rx_state_e;

  localparam int DROP_CNT_W = 16;

  // Field widths of the default 16x16 array with a 16-bit timestamp
  localparam int DEF_TS_W = 16;
  localparam int DEF_Y_W  = 4;
  localparam int DEF_X_W  = 4;

  typedef struct packed {
    evt_type_e           typ;
    logic [DEF_TS_W-1:0] ts;
    logic [DEF_Y_W-1:0]  y;
    logic [DEF_X_W-1:0]  x;
  } evt_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is presented on data_o while not empty.
module sync_fifo_fwft #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is refused even when a pop happens in the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/aer_event_receiver.sv
// Receiver end of the arbiter address-event handshake: captures (x,y), acknowledges with a
// 4-phase handshake, timestamps, buffers and streams words; inserts a marker on timestamp wrap.
module aer_event_receiver
  import ebc_rx_pkg::*;
#(
  parameter  int ROWS         = 16,
  parameter  int COLS         = 16,
  parameter  int TS_W         = 16,
  parameter  int FIFO_DEPTH   = 8,
  parameter  bit DROP_ON_FULL = 1'b0,
  localparam int Y_W          = $clog2(ROWS),
  localparam int X_W          = $clog2(COLS),
  localparam int WORD_W       = 2 + TS_W + Y_W + X_W,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  active_i,
  input  logic [X_W-1:0]        x_add_i,
  input  logic [Y_W-1:0]        y_add_i,
  output logic                  ack_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [WORD_W-1:0]     evt_data_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_count_o
);

  typedef struct packed {
    evt_type_e       typ;
    logic [TS_W-1:0] ts;
    logic [Y_W-1:0]  y;
    logic [X_W-1:0]  x;
  } word_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  rx_state_e             state_q;
  logic                  ack_q;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic                  wrap_pend_q, wrap_pend_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                  marker_push, accept, evt_push, evt_drop;
  word_t                 push_word;

  // The marker owns the push port whenever one is pending, so accepting waits for it
  always_comb begin
    marker_push = wrap_pend_q & ~fifo_full;
    accept      = (state_q == IDLE) & active_i & ~wrap_pend_q & (~fifo_full | DROP_ON_FULL);
    evt_push    = accept & ~fifo_full;
    evt_drop    = accept & fifo_full;
    fifo_push   = marker_push | evt_push;
    fifo_pop    = ~fifo_empty & evt_ready_i;

    push_word = '0;
    if (marker_push) begin
      push_word.typ = EVT_WRAP;
    end else begin
      push_word.typ = EVT_PIX;
      push_word.ts  = ts_q;
      push_word.y   = y_add_i;
      push_word.x   = x_add_i;
    end
  end

  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    wrap_pend_d = (&ts_q) | (wrap_pend_q & ~marker_push);
    overflow_d  = overflow_q | evt_drop;
    drop_cnt_d  = evt_drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q        <= '0;
      wrap_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      ts_q        <= ts_d;
      wrap_pend_q <= wrap_pend_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Handshake FSM; ack is registered and high only during the ACK cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK:      state_q <= WAIT_LOW;
        WAIT_LOW: if (!active_i) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (push_word),
    .pop_i   (fifo_pop),
    .data_o  (evt_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign ack_o        = ack_q;
  assign evt_valid_o  = ~fifo_empty;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_aer_event_receiver.sv
// Bench for aer_event_receiver: backpressure, drop and narrow-timestamp instances driven from one
// directed/randomized sequence, with a word-stream scoreboard for the backpressure instance.
module tb_aer_event_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;

  logic        act_a, ready_a, ack_a, valid_a, ovf_a;
  logic [3:0]  x_a, y_a, lvl_a;
  logic [25:0] data_a;
  logic [15:0] drop_a;

  logic        act_b, ready_b, ack_b, valid_b, ovf_b;
  logic [3:0]  x_b, y_b, lvl_b;
  logic [25:0] data_b;
  logic [15:0] drop_b;

  logic        act_c, ready_c, ack_c, valid_c, ovf_c;
  logic [3:0]  x_c, y_c, lvl_c;
  logic [13:0] data_c;
  logic [15:0] drop_c;

  aer_event_receiver #(.TS_W(16), .FIFO_DEPTH(8), .DROP_ON_FULL(1'b0)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .active_i(act_a), .x_add_i(x_a), .y_add_i(y_a),
    .ack_o(ack_a), .evt_valid_o(valid_a), .evt_ready_i(ready_a), .evt_data_o(data_a),
    .fifo_level_o(lvl_a), .overflow_o(ovf_a), .drop_count_o(drop_a));

  aer_event_receiver #(.TS_W(16), .FIFO_DEPTH(8), .DROP_ON_FULL(1'b1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .active_i(act_b), .x_add_i(x_b), .y_add_i(y_b),
    .ack_o(ack_b), .evt_valid_o(valid_b), .evt_ready_i(ready_b), .evt_data_o(data_b),
    .fifo_level_o(lvl_b), .overflow_o(ovf_b), .drop_count_o(drop_b));

  aer_event_receiver #(.TS_W(4), .FIFO_DEPTH(8), .DROP_ON_FULL(1'b0)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .active_i(act_c), .x_add_i(x_c), .y_add_i(y_c),
    .ack_o(ack_c), .evt_valid_o(valid_c), .evt_ready_i(ready_c), .evt_data_o(data_c),
    .fifo_level_o(lvl_c), .overflow_o(ovf_c), .drop_count_o(drop_c));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode;
  int          n_ack_a = 0;
  int          n_ack_b = 0;
  int          n0;
  logic [15:0] ts_m;
  logic [25:0] q_a[$];
  logic [25:0] q_b[$];
  logic        got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: pop-check dut_a's stream, advance, then record words implied by fresh acks
  task automatic tick();
    logic [15:0] ts_prev;
    logic        rst_prev;
    ready_a = (rdy_mode == 2) ? ($urandom_range(1) != 0) : (rdy_mode != 0);
    if (valid_a && ready_a && !reset_i) begin
      if (q_a.size() == 0) check("a_unexpected_word", 64'(data_a), 64'(0));
      else check("a_word", 64'(data_a), 64'(q_a.pop_front()));
    end
    ts_prev  = ts_m;
    rst_prev = reset_i;
    @(posedge clk);
    #1;
    ts_m = rst_prev ? 16'd0 : ts_m + 16'd1;
    if (rst_prev) begin
      q_a.delete();
      q_b.delete();
    end
    if (ack_a) begin
      q_a.push_back({2'b01, ts_prev, y_a, x_a});
      n_ack_a++;
    end
    if (ack_b) begin
      q_b.push_back({2'b01, ts_prev, y_b, x_b});
      n_ack_b++;
    end
  endtask

  task automatic hs(input int which, input logic [3:0] x, input logic [3:0] y, input int hold,
                    output logic ok);
    ok = 1'b0;
    if (which == 0) begin x_a = x; y_a = y; act_a = 1'b1; end
    else            begin x_b = x; y_b = y; act_b = 1'b1; end
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = (which == 0) ? ack_a : ack_b;
    end
    check("hs_ack_seen", 64'(ok), 64'(1));
    repeat (hold) tick();
    if (which == 0) act_a = 1'b0;
    else            act_b = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    rdy_mode = 0;
    act_a = 0; x_a = 0; y_a = 0; ready_a = 0;
    act_b = 0; x_b = 0; y_b = 0; ready_b = 0;
    act_c = 0; x_c = 0; y_c = 0; ready_c = 1;
    ts_m = 16'd0;
    tick();
    tick();

    // Reset state
    check("rst_ack_a",   64'(ack_a),   64'(0));
    check("rst_valid_a", 64'(valid_a), 64'(0));
    check("rst_data_a",  64'(data_a),  64'(0));
    check("rst_level_a", 64'(lvl_a),   64'(0));
    check("rst_ovf_a",   64'(ovf_a),   64'(0));
    check("rst_drop_a",  64'(drop_a),  64'(0));
    check("rst_ack_b",   64'(ack_b),   64'(0));
    check("rst_valid_c", 64'(valid_c), 64'(0));
    reset_i = 1'b0;

    // Single event x=5,y=9 accepted at ts=100
    for (int i = 0; i < 300 && ts_m != 16'd100; i++) tick();
    check("t1_ts_reached", 64'(ts_m), 64'(100));
    rdy_mode = 1;
    n0 = n_ack_a;
    x_a = 4'd5; y_a = 4'd9; act_a = 1'b1;
    tick();
    check("t1_ack_n1",   64'(ack_a),   64'(1));
    check("t1_valid_n1", 64'(valid_a), 64'(1));
    check("t1_data_n1",  64'(data_a),  64'({2'b01, 16'd100, 4'd9, 4'd5}));
    tick();
    check("t1_ack_n2",   64'(ack_a),   64'(0));

    // Active held high: one ack, one word; release and re-raise gives a second
    repeat (9) tick();
    check("t2_one_ack",  64'(n_ack_a - n0), 64'(1));
    check("t2_one_word", 64'(q_a.size()),   64'(0));
    check("t2_valid",    64'(valid_a),      64'(0));
    act_a = 1'b0;
    tick();
    tick();
    n0 = n_ack_a;
    hs(0, 4'hA, 4'h3, 0, got);
    check("t2_second_ack", 64'(n_ack_a - n0), 64'(1));
    repeat (3) tick();
    check("t2_drained", 64'(q_a.size()), 64'(0));

    // Randomized addresses, hold times and downstream readiness
    rdy_mode = 2;
    for (int k = 0; k < 20; k++)
      hs(0, 4'($urandom_range(15)), 4'($urandom_range(15)), int'($urandom_range(3)), got);
    rdy_mode = 1;
    repeat (12) tick();
    check("rand_drained", 64'(q_a.size()), 64'(0));
    check("rand_valid",   64'(valid_a),    64'(0));

    // Backpressure: 8 accepted, 9th held off until a pop
    rdy_mode = 0;
    for (int k = 0; k < 8; k++) hs(0, 4'(k), 4'(k + 1), 0, got);
    check("t3_level_full", 64'(lvl_a), 64'(8));
    x_a = 4'd8; y_a = 4'd15; act_a = 1'b1;
    n0 = n_ack_a;
    repeat (6) tick();
    check("t3_no_ack_full", 64'(n_ack_a - n0), 64'(0));
    check("t3_level_held",  64'(lvl_a),        64'(8));
    check("t3_no_drop",     64'(drop_a),       64'(0));
    check("t3_no_ovf",      64'(ovf_a),        64'(0));
    rdy_mode = 1;
    tick();
    rdy_mode = 0;
    for (int i = 0; i < 10 && n_ack_a == n0; i++) tick();
    check("t3_ack_after_pop", 64'(n_ack_a - n0), 64'(1));
    act_a = 1'b0;
    tick();
    tick();
    check("t3_level_refill", 64'(lvl_a), 64'(8));
    rdy_mode = 1;
    repeat (12) tick();
    check("t3_drained", 64'(q_a.size()), 64'(0));

    // Drop-on-full: 9 acks, one drop, first 8 kept
    for (int k = 0; k < 9; k++) hs(1, 4'(15 - k), 4'(k), 0, got);
    check("t4_acks",     64'(n_ack_b), 64'(9));
    check("t4_overflow", 64'(ovf_b),   64'(1));
    check("t4_drops",    64'(drop_b),  64'(1));
    check("t4_level",    64'(lvl_b),   64'(8));
    for (int k = 0; k < 8; k++) begin
      check("t4_word", 64'(data_b), 64'(q_b[k]));
      ready_b = 1'b1;
      tick();
    end
    ready_b = 1'b0;
    check("t4_empty", 64'(valid_b), 64'(0));

    // Narrow timestamp: active rises in the wrap cycle, marker goes first
    for (int i = 0; i < 40 && ts_m[3:0] != 4'd0; i++) tick();
    check("t5_at_wrap", 64'(ts_m[3:0]), 64'(0));
    ready_c = 1'b0;
    x_c = 4'd3; y_c = 4'd7; act_c = 1'b1;
    tick();
    check("t5_marker_valid", 64'(valid_c), 64'(1));
    check("t5_marker_data",  64'(data_c),  64'({2'b10, 12'd0}));
    check("t5_no_ack_yet",   64'(ack_c),   64'(0));
    tick();
    check("t5_ack",   64'(ack_c), 64'(1));
    check("t5_level", 64'(lvl_c), 64'(2));
    ready_c = 1'b1;
    tick();
    check("t5_event_data", 64'(data_c), 64'({2'b01, 4'd1, 4'd7, 4'd3}));
    act_c = 1'b0;
    tick();

    // Reset in ACK with three words queued
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) hs(0, 4'(k + 2), 4'(k + 5), 0, got);
    check("t6_level3", 64'(lvl_a), 64'(3));
    x_a = 4'd1; y_a = 4'd1; act_a = 1'b1;
    tick();
    check("t6_in_ack", 64'(ack_a), 64'(1));
    reset_i = 1'b1;
    tick();
    check("t6_ack",   64'(ack_a),   64'(0));
    check("t6_valid", 64'(valid_a), 64'(0));
    check("t6_level", 64'(lvl_a),   64'(0));
    check("t6_data",  64'(data_a),  64'(0));
    check("t6_ovf_b", 64'(ovf_b),   64'(0));
    reset_i = 1'b0;
    act_a = 1'b0;
    tick();
    check("t6_idle_no_ack", 64'(ack_a), 64'(0));
    hs(0, 4'd12, 4'd6, 0, got);
    rdy_mode = 1;
    repeat (4) tick();
    check("t6_post_reset_drained", 64'(q_a.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
